// File: rtl/cp0_interrupt_unit_pkg.sv
// cp0_pkg: CP0 register numbers, bit positions and cause codes shared by the interrupt unit.
package cp0_pkg;
    localparam int STATUS_REG = 12;
    localparam int CAUSE_REG  = 13;
    localparam int EPC_REG    = 14;
    localparam int IE_BIT     = 0;
    localparam int EXL_BIT    = 1;
    localparam int IM_LO      = 8;
    localparam int TIMER_IRQ  = 7;
    localparam logic [4:0] EXC_INT = 5'd0;
endpackage

// File: rtl/cp0_interrupt_unit_if.sv
// cp0_interrupt_unit_if: core-side mfc0/mtc0/eret and interrupt-redirect signals of the CP0 interrupt unit.
interface cp0_interrupt_unit_if #(parameter int width = 64);
    logic [4:0]       regnum;
    logic [width-1:0] wr_data;
    logic             MTC0;
    logic             ERET;
    logic             stall;
    logic [width-1:0] next_pc;
    logic [width-1:0] rd_data;
    logic [width-1:0] EPC;
    logic             TakenInterrupt;
    logic             exception_level;
    modport master(
        output regnum, wr_data, MTC0, ERET, stall, next_pc,
        input  rd_data, EPC, TakenInterrupt, exception_level
    );
    modport slave(
        input  regnum, wr_data, MTC0, ERET, stall, next_pc,
        output rd_data, EPC, TakenInterrupt, exception_level
    );
endinterface

// File: rtl/cp0_interrupt_unit_register.sv
// cp0_register: enabled register primitive with asynchronous active-high reset to zero.
module cp0_register #(parameter int width = 1) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) q <= '0;
        else if (enable) q <= d;
    end
endmodule

// File: rtl/cp0_interrupt_unit.sv
// cp0_interrupt_unit: synchronises and masks interrupt lines, takes interrupts, and holds Status/Cause/EPC.
module cp0_interrupt_unit import cp0_pkg::*; #(
    parameter int width   = 64,
    parameter int NUM_IRQ = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] interrupt_sources,
    cp0_interrupt_unit_if.slave bus
);
    logic [NUM_IRQ-1:0] ip_q, im_q, im_d;
    logic               exl_q, exl_d, ie_q, ie_d;
    logic [width-1:0]   epc_q, epc_d, status_img, cause_img;
    logic [4:0]         exc_q, exc_d;
    logic               taken, wr_status, wr_epc, status_en, epc_en;

    // A take flushes any coincident mtc0/eret, so it overrides both.
    always_comb begin
        taken      = |(ip_q & im_q) & ie_q & ~exl_q & ~bus.stall;
        wr_status  = bus.MTC0 && bus.regnum == 5'(STATUS_REG);
        wr_epc     = bus.MTC0 && bus.regnum == 5'(EPC_REG);
        im_d       = (wr_status && !taken) ? bus.wr_data[IM_LO +: NUM_IRQ] : im_q;
        ie_d       = (wr_status && !taken) ? bus.wr_data[IE_BIT] : ie_q;
        exl_d      = taken | (wr_status ? bus.wr_data[EXL_BIT] : exl_q & ~bus.ERET);
        epc_d      = taken ? bus.next_pc : bus.wr_data;
        exc_d      = EXC_INT;
        status_en  = taken | wr_status | bus.ERET;
        epc_en     = taken | wr_epc;
        status_img = '0;
        status_img[IM_LO +: NUM_IRQ] = im_q;
        status_img[EXL_BIT] = exl_q;
        status_img[IE_BIT]  = ie_q;
        cause_img  = '0;
        cause_img[IM_LO +: NUM_IRQ] = ip_q;
        cause_img[6:2] = exc_q;
    end

    assign bus.TakenInterrupt  = taken;
    assign bus.EPC             = epc_q;
    assign bus.exception_level = exl_q;
    assign bus.rd_data = bus.regnum == 5'(STATUS_REG) ? status_img :
                         bus.regnum == 5'(CAUSE_REG)  ? cause_img  :
                         bus.regnum == 5'(EPC_REG)    ? epc_q      : '0;

    cp0_register #(.width(NUM_IRQ + 2)) u_status (
        .clock(clock), .reset(reset), .enable(status_en),
        .d({im_d, exl_d, ie_d}), .q({im_q, exl_q, ie_q})
    );
    cp0_register #(.width(width)) u_epc (
        .clock(clock), .reset(reset), .enable(epc_en), .d(epc_d), .q(epc_q)
    );
    cp0_register #(.width(NUM_IRQ)) u_ip (
        .clock(clock), .reset(reset), .enable(1'b1), .d(interrupt_sources), .q(ip_q)
    );
    cp0_register #(.width(5)) u_exc (
        .clock(clock), .reset(reset), .enable(taken), .d(exc_d), .q(exc_q)
    );
endmodule
